// File: rtl/alu_issue_stage.sv
// Decode/issue stage ahead of the ALU: register file, RAW scoreboard, one-entry output register.
// Define ISSUE_WB_BYPASS_EN to let a same-cycle writeback satisfy a pending source and feed its operand.
module alu_issue_stage #(
  parameter int DATA_W         = 32,
  parameter bit RF_RESET_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_in1,
  output logic [DATA_W-1:0] out_in2,
  output logic [2:0]        out_aluop,
  output logic [4:0]        out_dest,
  output logic              out_wen,
  output logic              out_branch,
  output logic              illegal,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLL = 3'd4;
  localparam logic [2:0] ALU_SRL = 3'd5;
  localparam logic [2:0] ALU_SLT = 3'd6;

  logic [DATA_W-1:0] r_rf [32];
  logic [31:0]       r_pending;
  logic              r_outValid;
  logic [DATA_W-1:0] r_in1;
  logic [DATA_W-1:0] r_in2;
  logic [2:0]        r_aluop;
  logic [4:0]        r_dest;
  logic              r_wen;
  logic              r_branch;
  logic              r_illegal;

  logic [5:0]        w_op;
  logic [5:0]        w_funct;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [4:0]        w_rd;
  logic [4:0]        w_shamt;
  logic [DATA_W-1:0] w_sImm;
  logic [DATA_W-1:0] w_zImm;
  logic [DATA_W-1:0] w_shamtExt;
  logic [DATA_W-1:0] w_rsVal;
  logic [DATA_W-1:0] w_rtVal;
  logic              w_rsBusy;
  logic              w_rtBusy;
  logic              w_legal;
  logic              w_useRt;
  logic              w_writes;
  logic              w_branch;
  logic              w_wen;
  logic [2:0]        w_aluop;
  logic [4:0]        w_dest;
  logic [DATA_W-1:0] w_in1;
  logic [DATA_W-1:0] w_in2;
  logic              w_hazard;
  logic              w_slotFree;
  logic              w_accept;
  logic [31:0]       w_setMask;
  logic [31:0]       w_clrMask;

  assign w_op       = in_instr[31:26];
  assign w_rs       = in_instr[25:21];
  assign w_rt       = in_instr[20:16];
  assign w_rd       = in_instr[15:11];
  assign w_shamt    = in_instr[10:6];
  assign w_funct    = in_instr[5:0];
  assign w_sImm     = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
  assign w_zImm     = {{(DATA_W-16){1'b0}}, in_instr[15:0]};
  assign w_shamtExt = {{(DATA_W-5){1'b0}}, w_shamt};

  // r0 reads as zero and is never busy; bypass treats a matching writeback as already landed
  always_comb begin
    w_rsVal  = (w_rs == 5'd0) ? '0 : r_rf[w_rs];
    w_rtVal  = (w_rt == 5'd0) ? '0 : r_rf[w_rt];
    w_rsBusy = (w_rs != 5'd0) && r_pending[w_rs];
    w_rtBusy = (w_rt != 5'd0) && r_pending[w_rt];
`ifdef ISSUE_WB_BYPASS_EN
    if (wb_en && (wb_addr == w_rs) && (w_rs != 5'd0)) begin
      w_rsVal  = wb_data;
      w_rsBusy = 1'b0;
    end
    if (wb_en && (wb_addr == w_rt) && (w_rt != 5'd0)) begin
      w_rtVal  = wb_data;
      w_rtBusy = 1'b0;
    end
`endif
  end

  always_comb begin
    w_legal  = 1'b0;
    w_useRt  = 1'b0;
    w_writes = 1'b1;
    w_branch = 1'b0;
    w_aluop  = ALU_ADD;
    w_dest   = w_rt;
    w_in1    = w_rsVal;
    w_in2    = w_sImm;
    case (w_op)
      6'h00: begin
        w_legal = 1'b1;
        w_useRt = 1'b1;
        w_dest  = w_rd;
        w_in2   = w_rtVal;
        case (w_funct)
          6'h20, 6'h21: w_aluop = ALU_ADD;
          6'h22, 6'h23: w_aluop = ALU_SUB;
          6'h24:        w_aluop = ALU_AND;
          6'h25:        w_aluop = ALU_OR;
          6'h2A:        w_aluop = ALU_SLT;
          6'h00: begin
            w_aluop = ALU_SLL;
            w_in1   = w_rtVal;
            w_in2   = w_shamtExt;
          end
          6'h02: begin
            w_aluop = ALU_SRL;
            w_in1   = w_rtVal;
            w_in2   = w_shamtExt;
          end
          default: w_legal = 1'b0;
        endcase
      end
      6'h08, 6'h09: w_legal = 1'b1;
      6'h0A: begin
        w_legal = 1'b1;
        w_aluop = ALU_SLT;
      end
      6'h0C: begin
        w_legal = 1'b1;
        w_aluop = ALU_AND;
        w_in2   = w_zImm;
      end
      6'h0D: begin
        w_legal = 1'b1;
        w_aluop = ALU_OR;
        w_in2   = w_zImm;
      end
      6'h04: begin
        w_legal  = 1'b1;
        w_useRt  = 1'b1;
        w_writes = 1'b0;
        w_branch = 1'b1;
        w_aluop  = ALU_SUB;
        w_dest   = 5'd0;
        w_in2    = w_rtVal;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_wen      = w_writes && (w_dest != 5'd0);
  assign w_hazard   = w_rsBusy || (w_useRt && w_rtBusy);
  assign w_slotFree = !r_outValid || out_ready;
  assign in_ready   = w_slotFree && !(w_legal && w_hazard);
  assign w_accept   = in_valid && in_ready;
  assign w_setMask  = (w_accept && w_legal && w_wen) ? (32'd1 << w_dest) : 32'd0;
  assign w_clrMask  = wb_en ? (32'd1 << wb_addr) : 32'd0;

  // Set is applied after clear so a same-cycle issue to the written register stays pending
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_illegal  <= 1'b0;
      r_in1      <= '0;
      r_in2      <= '0;
      r_aluop    <= 3'd0;
      r_dest     <= 5'd0;
      r_wen      <= 1'b0;
      r_branch   <= 1'b0;
      r_pending  <= 32'd0;
    end else begin
      r_illegal <= w_accept && !w_legal;
      r_pending <= ((r_pending & ~w_clrMask) | w_setMask) & ~32'd1;
      if (w_accept && w_legal) begin
        r_outValid <= 1'b1;
        r_in1      <= w_in1;
        r_in2      <= w_in2;
        r_aluop    <= w_aluop;
        r_dest     <= w_dest;
        r_wen      <= w_wen;
        r_branch   <= w_branch;
      end else if (w_slotFree) begin
        r_outValid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rf[0] <= '0;
      if (RF_RESET_CLEAR) begin
        for (int i = 1; i < 32; i++) r_rf[i] <= '0;
      end
    end else if (wb_en && (wb_addr != 5'd0)) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  assign out_valid  = r_outValid;
  assign out_in1    = r_in1;
  assign out_in2    = r_in2;
  assign out_aluop  = r_aluop;
  assign out_dest   = r_dest;
  assign out_wen    = r_wen;
  assign out_branch = r_branch;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios then random traffic against a register/scoreboard model.
// Honours ISSUE_WB_BYPASS_EN the same way the design does.
module tb_alu_issue_stage;

`ifdef ISSUE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_in1;
  logic [31:0] out_in2;
  logic [2:0]  out_aluop;
  logic [4:0]  out_dest;
  logic        out_wen;
  logic        out_branch;
  logic        illegal;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_in1(out_in1), .out_in2(out_in2),
    .out_aluop(out_aluop), .out_dest(out_dest), .out_wen(out_wen), .out_branch(out_branch),
    .illegal(illegal), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        legal;
    logic        br;
    logic        writes;
    logic        useRt;
    logic [2:0]  op;
    logic [4:0]  dest;
    logic [31:0] a;
    logic [31:0] b;
  } dec_t;

  logic [31:0] mR [32];
  bit          mPend [32];
  bit          mValid;
  bit          mIll;
  bit          mAcc;
  dec_t        mOut;

  function automatic logic [31:0] srcVal(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (BYP && wb_en && wb_addr == a) return wb_data;
    return mR[a];
  endfunction

  function automatic bit busy(input logic [4:0] a);
    return (a != 5'd0) && mPend[a] && !(BYP && wb_en && wb_addr == a);
  endfunction

  // Instruction semantics from the ISA tables, expressed as operand pairs per op class
  function automatic dec_t refDecode(input logic [31:0] ins);
    dec_t d;
    logic [31:0] rsV, rtV, sImm, zImm, sh;
    rsV  = srcVal(ins[25:21]);
    rtV  = srcVal(ins[20:16]);
    sImm = 32'(signed'(ins[15:0]));
    zImm = {16'd0, ins[15:0]};
    sh   = {27'd0, ins[10:6]};
    d = '0;
    d.legal = 1'b1; d.writes = 1'b1; d.a = rsV;
    if (ins[31:26] == 6'h00) begin
      d.dest = ins[15:11]; d.useRt = 1'b1; d.b = rtV;
      case (ins[5:0])
        6'h20, 6'h21: d.op = 3'd0;
        6'h22, 6'h23: d.op = 3'd1;
        6'h24:        d.op = 3'd2;
        6'h25:        d.op = 3'd3;
        6'h2A:        d.op = 3'd6;
        6'h00:        begin d.op = 3'd4; d.a = rtV; d.b = sh; end
        6'h02:        begin d.op = 3'd5; d.a = rtV; d.b = sh; end
        default:      d.legal = 1'b0;
      endcase
    end else begin
      d.dest = ins[20:16];
      case (ins[31:26])
        6'h08, 6'h09: begin d.op = 3'd0; d.b = sImm; end
        6'h0A:        begin d.op = 3'd6; d.b = sImm; end
        6'h0C:        begin d.op = 3'd2; d.b = zImm; end
        6'h0D:        begin d.op = 3'd3; d.b = zImm; end
        6'h04: begin
          d.op = 3'd1; d.b = rtV; d.br = 1'b1; d.writes = 1'b0; d.useRt = 1'b1; d.dest = 5'd0;
        end
        default: d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check readiness, advance the model on the edge, then check the registered outputs
  task automatic applyStimulus();
    dec_t d;
    bit hold, rdy;
    #1;
    d    = refDecode(in_instr);
    hold = mValid && !out_ready;
    rdy  = !hold && !(d.legal && (busy(in_instr[25:21]) || (d.useRt && busy(in_instr[20:16]))));
    if (rst_n) checkOutput("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    @(posedge clk);
    if (!rst_n) begin
      mValid = 0; mIll = 0; mAcc = 0; mOut = '0;
      for (int i = 0; i < 32; i++) begin mR[i] = 32'd0; mPend[i] = 0; end
    end else begin
      mAcc = in_valid && rdy;
      mIll = mAcc && !d.legal;
      if (mAcc && d.legal) begin
        mOut = d; mValid = 1;
      end else if (!hold) begin
        mValid = 0;
      end
      if (wb_en && wb_addr != 5'd0) begin mR[wb_addr] = wb_data; mPend[wb_addr] = 0; end
      if (mAcc && d.legal && d.writes && d.dest != 5'd0) mPend[d.dest] = 1;
    end
    #1;
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, mValid});
    checkOutput("illegal", {31'd0, illegal}, {31'd0, mIll});
    checkOutput("out_in1", out_in1, mOut.a);
    checkOutput("out_in2", out_in2, mOut.b);
    checkOutput("out_aluop", {29'd0, out_aluop}, {29'd0, mOut.op});
    checkOutput("out_dest", {27'd0, out_dest}, {27'd0, mOut.dest});
    checkOutput("out_wen", {31'd0, out_wen}, {31'd0, mOut.writes && mOut.dest != 5'd0});
    checkOutput("out_branch", {31'd0, out_branch}, {31'd0, mOut.br});
  endtask

  function automatic logic [31:0] randInstr();
    logic [5:0] ops [8];
    logic [5:0] fns [10];
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h04, 6'h00};
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h3F};
    op = ops[$urandom_range(0, 7)];
    if ($urandom_range(0, 15) == 0) op = 6'($urandom);
    fn = fns[$urandom_range(0, 9)];
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom), fn};
  endfunction

  task automatic writeBack(input logic [4:0] a, input logic [31:0] v);
    wb_en = 1'b1; wb_addr = a; wb_data = v;
    applyStimulus();
    wb_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b1;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    applyStimulus();
    applyStimulus();
    rst_n = 1'b1;

    writeBack(5'd1, 32'd10);
    writeBack(5'd2, 32'd5);

    in_valid = 1'b1; in_instr = 32'h00221820;
    applyStimulus();
    checkOutput("add_in1", out_in1, 32'd10);
    checkOutput("add_in2", out_in2, 32'd5);
    checkOutput("add_dest", {27'd0, out_dest}, 32'd3);

    in_instr = 32'h00612022;
    applyStimulus();
    applyStimulus();
    checkOutput("raw_stalled", {31'd0, out_valid}, 32'd0);
    writeBack(5'd3, 32'd15);
    if (!mAcc) applyStimulus();
    in_valid = 1'b0;
    checkOutput("raw_issued", {31'd0, out_valid}, 32'd1);
    checkOutput("raw_in1", out_in1, 32'd15);

    in_valid = 1'b1; in_instr = 32'h2005FFFF;
    applyStimulus();
    checkOutput("addi_in2", out_in2, 32'hFFFFFFFF);
    out_ready = 1'b0; in_instr = 32'h3405FFFF;
    repeat (3) applyStimulus();
    checkOutput("bp_held_in2", out_in2, 32'hFFFFFFFF);
    out_ready = 1'b1;
    applyStimulus();
    checkOutput("ori_in2", out_in2, 32'h0000FFFF);
    checkOutput("ori_op", {29'd0, out_aluop}, 32'd3);

    in_instr = 32'h00013100;
    applyStimulus();
    checkOutput("sll_in1", out_in1, 32'd10);
    checkOutput("sll_in2", out_in2, 32'd4);
    checkOutput("sll_op", {29'd0, out_aluop}, 32'd4);

    in_instr = 32'h00220020;
    applyStimulus();
    checkOutput("r0_wen", {31'd0, out_wen}, 32'd0);

    in_instr = 32'h10220000;
    applyStimulus();
    checkOutput("beq_op", {29'd0, out_aluop}, 32'd1);
    checkOutput("beq_branch", {31'd0, out_branch}, 32'd1);

    in_instr = 32'hFC000000;
    applyStimulus();
    checkOutput("ill_pulse", {31'd0, illegal}, 32'd1);
    in_valid = 1'b0;
    applyStimulus();
    checkOutput("ill_done", {31'd0, illegal}, 32'd0);

    in_valid = 1'b1; in_instr = 32'h00221820; out_ready = 1'b0;
    applyStimulus();
    in_valid = 1'b0; rst_n = 1'b0; wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'd99;
    applyStimulus();
    checkOutput("rst_drop", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1; wb_en = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00612022;
    applyStimulus();
    checkOutput("rst_issue", {31'd0, out_valid}, 32'd1);
    in_instr = 32'h00E03820;
    applyStimulus();
    checkOutput("rst_wb_ignored", out_in1, 32'd0);

    $display("[TB] random phase");
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      wb_en     = ($urandom_range(0, 2) == 0);
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      in_instr  = randInstr();
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage directly upstream of the ALU.
- Accepts 32-bit MIPS R/I instructions over a valid/ready handshake and reads a 32x32 register file.
- Tracks pending writes in a scoreboard and stalls on read-after-write (RAW) hazards.
- Drives registered operands in1/in2 and the 3-bit aluop in the ALU encoding: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 slt.
- Results return through a writeback port that updates the register file and clears the scoreboard.

Parameters:
- DATA_W, 32, operand and register width.
- RF_RESET_CLEAR, 1, when 1, reset zeroes all 32 registers; when 0, only r0 and control state are reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  stage can accept instruction.
- in_instr  in  32  MIPS instruction word.
- out_valid  out  1  issued operation valid.
- out_ready  in  1  downstream accepts operation.
- out_in1  out  DATA_W  ALU operand 1.
- out_in2  out  DATA_W  ALU operand 2.
- out_aluop  out  3  ALU op code.
- out_dest  out  5  destination register.
- out_wen  out  1  result must be written back.
- out_branch  out  1  beq compare op; no writeback.
- illegal  out  1  one-cycle pulse for an unsupported instruction.
- wb_en  in  1  writeback strobe.
- wb_addr  in  5  writeback register.
- wb_data  in  DATA_W  writeback value.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid, out_wen, out_branch, illegal, out_aluop, out_dest, out_in1, out_in2 all 0.
  - Scoreboard cleared.
  - Registers zeroed per RF_RESET_CLEAR.
  - An in-flight output is dropped.
  - wb_en is ignored during reset.
- Decode, R-type (op=0), dest=rd:
  - funct 0x20/0x21 -> add; 0x22/0x23 -> sub; 0x24 -> and; 0x25 -> or; 0x2A -> slt; in1=R[rs], in2=R[rt].
  - funct 0x00 -> sll; 0x02 -> srl; in1=R[rt], in2=zero-extended shamt.
- Decode, I-type, dest=rt:
  - 0x08/0x09 -> add, sign-extended imm.
  - 0x0A -> slt, sign-extended imm.
  - 0x0C -> and, zero-extended imm.
  - 0x0D -> or, zero-extended imm.
  - in1=R[rs] for all I-type ops.
- beq (0x04): sub, in1=R[rs], in2=R[rt], out_branch=1, out_wen=0.
- Any other encoding is illegal.
- out_wen=1 iff the op writes and dest!=0. A write to r0 issues with out_wen=0.
- Hazard: a source register (rs, and rt where used) is r!=0 with its pending bit set.
  - r0 always reads 0 and is never pending.
- in_ready = (!out_valid || out_ready) && !hazard.
  - in_ready depends on in_instr, never on in_valid.
- Accept on in_valid && in_ready. Latency is 1 cycle: out_* register on that edge and out_valid=1.
- Output register holds stable while out_valid && !out_ready.
- Completion without a new accept: out_valid clears on out_ready.
- Back-to-back throughput is 1/cycle.
- Scoreboard:
  - Accept with out_wen=1 sets pending[dest].
  - wb_en writes R[wb_addr] (ignored when wb_addr=0) and clears pending[wb_addr].
  - If set and clear hit the same register in the same cycle, set wins.
- Illegal instruction:
  - Accepted whenever (!out_valid || out_ready); it is not subject to hazards.
  - Produces no output: out_valid=0 next cycle, unless the prior output is held.
  - illegal=1 for exactly one cycle.
- Register reads for hazard-free accepts use the current register contents. Same-cycle writeback forwarding is defined under Optional Feature.

Optional Feature:
- Macro ISSUE_WB_BYPASS_EN.
- Defined:
  - A same-cycle wb_en to a source register counts as not pending for the hazard check.
  - The operand takes wb_data, so the instruction issues in that cycle.
- Undefined:
  - Hazard uses the pending bit only, and the instruction issues the cycle after writeback.
  - The source value is read from the register file.

Test Plan:
- Reset then program: wb r1=10, wb r2=5; issue add r3,r1,r2 (0x00221820) -> next cycle out_valid=1, in1=10, in2=5, aluop=0, dest=3, out_wen=1.
- RAW stall: issue add r3,r1,r2, then sub r4,r3,r1 -> in_ready=0 until wb r3=15.
  - Bypass defined: issues in the wb cycle with in1=15.
  - Bypass undefined: issues one cycle later with in1=15.
- Backpressure: out_ready=0 for 3 cycles after an issue -> out_* stable, in_ready=0; out_ready=1 -> next instruction accepted that cycle.
- Immediates:
  - addi r5,r0,-1 -> in2=0xFFFFFFFF, aluop=0.
  - ori r5,r0,0xFFFF -> in2=0x0000FFFF, aluop=3.
  - sll r6,r1,4 -> in1=R[1], in2=4, aluop=4.
- Corner cases:
  - add r0,r1,r2 -> out_wen=0, no pending set.
  - beq r1,r2 -> aluop=1, out_branch=1.
  - Opcode 0x3F -> illegal pulse 1 cycle, out_valid stays 0.
- Reset mid-operation: rst_n=0 with out_valid=1 and pending[3]=1 -> next cycle out_valid=0; sub r4,r3,r1 then accepted immediately.
